uart_tx_fsm: RTL
================

# uart_tx_fsm

UART transmitter: accepts one parallel byte per valid/ready handshake and serialises it onto `tx` as start bit, data bits LSB-first, optional parity bit and one stop bit. Bit timing comes from an internal clocks-per-bit counter. It is the transmit-side counterpart of the receiver FSM, and its frame format matches that receiver exactly: same data width, same parity sense, same stop-bit check.

## Interface
- `DATA_BITS`, default 8: data bits per frame (5..8).
- `CLKS_PER_BIT`, default 16: `clk` cycles per serial bit (>= 2).
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity. Only used when parity is compiled in.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  DATA_BITS  byte to send; sampled only on handshake.
- `tx_valid`  in  1  upstream has data.
- `tx_ready`  out  1  high only in IDLE; handshake = `tx_valid && tx_ready` at a rising edge.
- `tx`  out  1  serial line, registered; idle high.
- `tx_busy`  out  1  high in any state other than IDLE.
- `tx_done`  out  1  one-cycle pulse on the first IDLE cycle after a stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx`=1.
  - On handshake: latch `tx_data` into the shift register, compute the parity bit from the latched data, clear the bit-timer and bit index, go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - `tx` = shift-register bit 0.
  - Each time the bit-timer reaches CLKS_PER_BIT-1: shift right, increment the bit index.
  - After bit index DATA_BITS-1 completes, go to PARITY if compiled in, else STOP.
- PARITY:
  - `tx` = XOR of the latched data, XOR `PARITY_ODD`.
  - Held for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE with `tx_done`=1 for that one cycle.
- Bit-timer width: $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Never counts in IDLE.
- Bit index width: $clog2(DATA_BITS). Reset to 0 on entry to DATA.
- `tx_data` changes outside the handshake have no effect on a frame in flight.
- `tx_valid` while busy is ignored (`tx_ready`=0). Upstream holds the data until accepted.
- Reset mid-frame: the next edge forces IDLE, `tx`=1, and clears the timer and index. The partial frame is abandoned; no `tx_done`.
- Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, state IDLE, shift register 0.
- `rst` overrides any handshake in the same cycle.

## Timing
- Handshake at edge N: `tx` falls at edge N+1 (registered output).
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length: (2 + DATA_BITS + P) × CLKS_PER_BIT cycles, where P=1 with parity, else 0.
- `tx_ready` returns high on the same cycle as `tx_done`.
- Back-to-back, with `tx_valid` held high:
  - the next handshake happens in that IDLE cycle;
  - the next start bit begins one cycle later;
  - so there is exactly one extra idle-high cycle between frames.
- `tx_busy` = !`tx_ready`, combinational from the state register.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and parity register exist, and the frame carries a parity bit; `PARITY_ODD` selects its sense.
- `UART_TX_PARITY_EN` undefined:
  - PARITY state and parity logic are removed;
  - DATA goes directly to STOP;
  - `PARITY_ODD` is ignored;
  - frame = (2 + DATA_BITS) × CLKS_PER_BIT cycles.

## Test plan
- Reset idle:
  - Stimulus: assert `rst` 3 cycles with `tx_valid`=1.
  - Response: `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0 throughout; no frame starts while in reset.
- Single frame, parity on (CLKS_PER_BIT=4, even parity, `tx_data`=8'hA5):
  - Required `tx` sequence, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 0, 1.
  - `tx_done` pulses once, 44 cycles after the handshake edge.
- Parity sense, `tx_data`=8'h07:
  - `PARITY_ODD`=0: parity bit 1.
  - `PARITY_ODD`=1: parity bit 0.
- Back-to-back (`tx_valid` held, data 8'h00 then 8'hFF):
  - Second start bit begins exactly 1 cycle after the first frame's last stop cycle.
  - `tx_data` changing mid-frame does not alter the bits being sent.
- Reset mid-frame:
  - Stimulus: assert `rst` during DATA bit 3.
  - Response: `tx`=1 on the next edge, `tx_ready`=1, no `tx_done`; a new 8'h3C frame afterwards is sent correctly.
- Build without `UART_TX_PARITY_EN`, data 8'hA5:
  - Response: 40-cycle frame with stop immediately after data bit 7.

Source files
------------

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: valid/ready UART transmitter. Frame = start bit, DATA_BITS
// data bits LSB first, optional parity bit, one stop bit. Bit timing comes
// from an internal clocks-per-bit counter.
// Optional feature macro: UART_TX_PARITY_EN (adds the parity bit; PARITY_ODD
// selects odd/even sense). Without it the frame goes straight from the last
// data bit to the stop bit.
module uart_tx_fsm #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] INDEX_LAST = IW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [TW-1:0]        bit_timer;
  logic [IW-1:0]        bit_idx;
  logic                 bit_end;

`ifdef UART_TX_PARITY_EN
  logic parity_bit;
  logic parity_sense;
  assign parity_sense = (PARITY_ODD != 0);
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  // Last clock of the current serial bit.
  assign bit_end = (bit_timer == TIMER_LAST);

  // Handshake and status come straight from the state register.
  assign tx_ready = (state == S_IDLE);
  assign tx_busy  = ~tx_ready;

  // Frame sequencer; tx is loaded with the value of the bit being entered so
  // the line changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
      shreg      <= '0;
      bit_timer  <= '0;
      bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (state != S_IDLE) begin
        bit_timer <= bit_end ? '0 : bit_timer + 1'b1;
      end
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (tx_valid) begin
            shreg      <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^tx_data) ^ parity_sense;
`endif
            bit_timer  <= '0;
            bit_idx    <= '0;
            tx         <= 1'b0;
            state      <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == INDEX_LAST) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= S_PARITY;
`else
              tx    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              // shreg[0] is the bit just sent; shreg[1] is next after shift
              tx <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            tx      <= 1'b1;
            tx_done <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
